// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-to-register command engine and its ALU.
// Op codes, FSM state encodings and default widths live here so the datapath reuses them.
package reg_op_sequencer_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // NOP still retires a command but never touches the register file.
  function automatic logic op_writes_back(input op_e op);
    return (op != OP_NOP);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_alu.sv
// Purely combinational ALU (op, a, b -> y) with wrap-around arithmetic.
// Shared with the single-cycle datapath, so it carries no state.
module reg_op_alu
  import reg_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  logic [4:0] shamt;
  logic       lt_signed;

  assign shamt     = b_i[4:0];
  assign lt_signed = ($signed(a_i) < $signed(b_i));

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLT:  y_o = {{(DATA_W-1){1'b0}}, lt_signed};
      OP_SLL:  y_o = a_i << shamt;
      OP_NOP:  y_o = a_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Multi-cycle command engine: IDLE -> READ -> EXEC -> WRITE, one command per four cycles.
// Serialising commands keeps every READ strictly after the previous write edge.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; the source holds cmd_* stable while cmd_ready is low.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] alu_y;
  logic              addr_illegal;

  reg_op_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i (op_q),
    .a_i  (opa_q),
    .b_i  (opb_q),
    .y_o  (alu_y)
  );

  // Any out-of-range operand or destination suppresses the write-back.
  assign addr_illegal = (32'(rs_q) >= 32'(NUM_REGS)) ||
                        (32'(rt_q) >= 32'(NUM_REGS)) ||
                        (32'(rd_q) >= 32'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    cmd_ready     = 1'b0;
    rf_addr1      = '0;
    rf_addr2      = '0;
    rf_addr3      = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    done          = 1'b0;
    err           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          rs_d    = cmd_rs;
          rt_d    = cmd_rt;
          rd_d    = cmd_rd;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rf_addr1 = rs_q;
        rf_addr2 = rt_q;
        opa_d    = rf_read_data1;
        opb_d    = rf_read_data2;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_y;
        zero_d   = (alu_y == '0);
        err_d    = addr_illegal;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        // Reset gates the strobes so a WRITE that meets a reset edge never commits.
        rf_addr3      = rd_q;
        rf_write_data = result_q;
        rf_reg_write  = !err_q && op_writes_back(op_q) && !reset;
        done          = !reset;
        err           = err_q && !reset;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed plus randomized bench for reg_op_sequencer with a behavioural register-file model.
module tb_reg_op_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [4:0]  rf_addr1, rf_addr2, rf_addr3;
  logic [31:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic        rf_reg_write;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  // bench-side register file (4 regs, out-of-range reads return 0)
  logic [31:0] rf_mem [4];
  logic [31:0] load_vals [4];
  logic        load_en;
  // reference copy of architectural register state
  logic [31:0] regs_m [4];

  reg_op_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rs        (cmd_rs),
    .cmd_rt        (cmd_rt),
    .cmd_rd        (cmd_rd),
    .rf_addr1      (rf_addr1),
    .rf_addr2      (rf_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_addr3      (rf_addr3),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .done          (done),
    .result        (result),
    .zero          (zero),
    .err           (err),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_read_data1 = (rf_addr1 < 5'd4) ? rf_mem[rf_addr1[1:0]] : 32'h0;
  assign rf_read_data2 = (rf_addr2 < 5'd4) ? rf_mem[rf_addr2[1:0]] : 32'h0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= load_vals[i];
    end else if (rf_reg_write && rf_addr3 < 5'd4) begin
      rf_mem[rf_addr3[1:0]] <= rf_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a < 5'd4) ? regs_m[a[1:0]] : 32'h0;
  endfunction

  // reference ALU written from the op table with plain arithmetic
  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a;
    endcase
  endfunction

  task automatic preload(input logic [31:0] v0, v1, v2, v3);
    load_vals[0] = v0; load_vals[1] = v1; load_vals[2] = v2; load_vals[3] = v3;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) regs_m[i] = load_vals[i];
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s_r%0d", tag, i), rf_mem[i], regs_m[i]);
  endtask

  // driver: one command from handshake to retirement, checked cycle by cycle
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] rs, rt, rd,
                         input bit junk, input bit rst_in_write);
    logic [31:0] y;
    bit          e, we;
    int          n;
    y  = model_alu(op, model_read(rs), model_read(rt));
    e  = (rs >= 5'd4) || (rt >= 5'd4) || (rd >= 5'd4);
    we = !e && (op != 3'd7);
    n  = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    @(negedge clk);
    if (junk) begin
      cmd_op = 3'($urandom_range(0, 7)); cmd_rs = 5'($urandom_range(0, 31));
      cmd_rt = 5'($urandom_range(0, 31)); cmd_rd = 5'($urandom_range(0, 31));
    end else cmd_valid = 1'b0;
    check("read_ready", {31'b0, cmd_ready}, 32'd0);
    check("read_addr1", {27'b0, rf_addr1}, {27'b0, rs});
    check("read_addr2", {27'b0, rf_addr2}, {27'b0, rt});
    check("read_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    if (junk) begin
      cmd_op = 3'($urandom_range(0, 7)); cmd_rd = 5'($urandom_range(0, 31));
    end
    check("exec_ready", {31'b0, cmd_ready}, 32'd0);
    check("exec_we", {31'b0, rf_reg_write}, 32'd0);
    @(negedge clk);
    check("write_result", result, y);
    check("write_zero", {31'b0, zero}, {31'b0, (y == 32'h0)});
    check("write_ready", {31'b0, cmd_ready}, 32'd0);
    if (rst_in_write) begin
      reset = 1'b1;
      #1;
      check("rst_we", {31'b0, rf_reg_write}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_state", {30'b0, dbg_state}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd1);
      check_regs("rst");
      return;
    end
    check("write_done", {31'b0, done}, 32'd1);
    check("write_err", {31'b0, err}, {31'b0, e});
    check("write_we", {31'b0, rf_reg_write}, {31'b0, we});
    check("write_addr3", {27'b0, rf_addr3}, {27'b0, rd});
    check("write_data", rf_write_data, y);
    if (junk) cmd_valid = 1'b0;
    if (we) regs_m[rd[1:0]] = y;
    @(negedge clk);
    check("retire_done", {31'b0, done}, 32'd0);
    check("retire_ready", {31'b0, cmd_ready}, 32'd1);
    check("retire_state", {30'b0, dbg_state}, 32'd0);
    check_regs("retire");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_vals[i] = '0;
      regs_m[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_we", {31'b0, rf_reg_write}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_addr1", {27'b0, rf_addr1}, 32'd0);
    check("rst_addr3", {27'b0, rf_addr3}, 32'd0);
    check("rst_wdata", rf_write_data, 32'd0);

    preload(32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000001);
    run_cmd(3'd0, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);
    check("add_r0", rf_mem[0], 32'h00000000);
    check("add_zero", {31'b0, zero}, 32'd1);
    run_cmd(3'd1, 5'd1, 5'd3, 5'd1, 1'b0, 1'b0);
    check("sub_r1", rf_mem[1], 32'h9ABCDEEF);
    run_cmd(3'd5, 5'd1, 5'd3, 5'd2, 1'b0, 1'b0);
    check("slt_r2", rf_mem[2], 32'h00000001);

    preload(32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000001);
    run_cmd(3'd6, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0);
    check("sll_r3", rf_mem[3], 32'h2468ACF0);
    run_cmd(3'd7, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    check("nop_r0", rf_mem[0], 32'h12345678);

    run_cmd(3'd0, 5'd0, 5'd1, 5'd7, 1'b0, 1'b0);
    run_cmd(3'd4, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);

    // command held and changed while busy; the next one follows immediately
    run_cmd(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    run_cmd(3'd3, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    // reset during WRITE must suppress the register write
    preload(32'hCAFEF00D, 32'h00000011, 32'hA5A5A5A5, 32'h00000022);
    run_cmd(3'd0, 5'd1, 5'd3, 5'd2, 1'b0, 1'b1);

    // command presented together with reset is dropped
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_rd = 5'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    check("drop_ready", {31'b0, cmd_ready}, 32'd1);
    check("drop_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    check("drop_still_idle", {30'b0, dbg_state}, 32'd0);
    check_regs("drop");

    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0)
        preload($urandom, $urandom, $urandom, 32'($urandom_range(0, 40)));
      run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 4)),
              5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
